fp_addsub_arbiter: RTL and testbench
====================================

// Module: fp_addsub_arbiter
// PURPOSE
//  Shares one fp_addsub_pipeline among NUM_REQ requesters. Per cycle it picks at most
//  one request with a round-robin arbiter, maps SUB to ADD by flipping sign of operand B,
//  and drives the pipeline inputs from registers. It tracks the requester ID of every
//  in-flight op in a tag FIFO and routes each result plus its flags back to that requester.
// PARAMETERS
//  NUM_REQ       4         number of requesters (2..8)
//  PIPE_LAT      4         pipeline latency, valid_data_in -> valid_data_out, cycles
//  MAX_INFLIGHT  PIPE_LAT  tag FIFO depth = max outstanding ops (>=1)
//  ID_W          $clog2(NUM_REQ)  tag width (derived)
// PORTS
//  clk           in   1           clock, rising edge
//  rst           in   1           asynchronous, active-high reset
//  en            in   1           0 = no new grants; in-flight ops still complete
//  req_valid     in   NUM_REQ     request valid per requester
//  req_ready     out  NUM_REQ     one-hot grant; transfer = req_valid[i] & req_ready[i]
//  req_op        in   NUM_REQ     0 = ADD, 1 = SUB (a - b)
//  req_a, req_b  in   32*NUM_REQ  IEEE-754 single operands, requester i at [32i+:32]
//  req_rm        in   3*NUM_REQ   rounding mode per requester (fp_pkg encoding)
//  pipe_valid    out  1           to pipeline valid_data_in
//  pipe_in1/2    out  32          to pipeline in1/in2
//  pipe_rm       out  3           to pipeline rounding_mode
//  pipe_vout     in   1           from pipeline valid_data_out
//  pipe_out      in   32          from pipeline out
//  pipe_flags    in   4           {overflow,underflow,inexact,invalid_operation}
//  resp_valid    out  NUM_REQ     one-hot result strobe, single cycle
//  resp_data     out  32          result, valid with resp_valid
//  resp_flags    out  4           flags, same order as pipe_flags
//  tag_err       out  1           sticky: pipe_vout seen with tag FIFO empty
// BEHAVIOUR
//  - Reset: every output 0; rr pointer = NUM_REQ-1, so req 0 wins first; FIFO empty.
//  - Grant is combinational: can_issue = en & (count < MAX_INFLIGHT) | (count==MAX & pipe_vout).
//    Round-robin: the first i with req_valid[i], searching from ptr+1 with wrap.
//    req_ready is 0 when !can_issue. req_ready may depend on req_valid.
//  - On transfer, ptr <= i and the tag FIFO pushes i. Next cycle: pipe_valid=1,
//    pipe_in1=a, pipe_in2 = op ? {~b[31],b[30:0]} : b, pipe_rm=rm. Otherwise pipe_valid=0
//    and the data registers hold their value.
//  - Sign flip is applied to NaN/inf/zero too; the pipeline decides the special results.
//  - On pipe_vout: pop the tag. The next cycle gives resp_valid[tag]=1, resp_data=pipe_out
//    and resp_flags=pipe_flags. There is no response backpressure.
//  - Latency from the transfer edge to resp_valid is PIPE_LAT+2 cycles. Results return in order.
//  - Push and pop in the same cycle leave count unchanged; this is legal at full.
//  - pipe_vout with an empty FIFO: no resp, no pop, tag_err <= 1 until rst.
//  - en deasserted mid-stream: already issued ops still return; none are lost.
//  - Reset asserted mid-operation: all tags are dropped. Results returning after reset
//    raise tag_err; the pipeline is reset on the same rst.
// STRUCTURE
//  - fp_pkg: add OP_ADD/OP_SUB localparams and fp_flags_t packed struct
//    {overflow,underflow,inexact,invalid}. Reuse fp_32b_t and the RNE/RDN/... encodings.
//  - Sub-module rr_arbiter #(N): req, en, grant_onehot, grant_idx, ptr update on accept.
//  - Tag FIFO stays inline: circular buffer with wr/rd pointers and a count of
//    width $clog2(MAX_INFLIGHT+1).
// TESTING (fp_addsub_pipeline model or real instance, PIPE_LAT=4)
//  - Single: req0 ADD 3F800000+40000000 (1+2), RNE -> resp_valid[0] 6 cycles later,
//    resp_data 40400000, flags 0000.
//  - SUB map: req2 SUB 40400000-3F800000 -> pipe_in2=BF800000; resp_valid[2], data 40000000.
//  - Round-robin: all 4 valid continuously -> grants 0,1,2,3,0,...; each resp routed to
//    its own index in order.
//  - Full: MAX_INFLIGHT=2, continuous req -> req_ready low once count=2 and high on
//    cycles with pipe_vout. No drop, no duplicate.
//  - Special: req1 SUB 7F800000-7F800000 -> data 7FC00000, invalid=1;
//    ADD 7FA00000 (sNaN) -> 7FE00000.
//  - Error/reset: force pipe_vout with FIFO empty -> tag_err=1, no resp_valid;
//    rst mid-flight -> all outputs 0 at once.

Source files
------------

// File: rtl/fp_addsub_arbiter_pkg.sv
// Shared types for the fp add/sub arbiter slice.
//   fp_32b_t    : IEEE-754 single split into sign/exponent/mantissa
//   RNE..RMM    : rounding-mode encodings understood by the add/sub pipeline
//   OP_ADD/SUB  : request opcode encoding
//   fp_flags_t  : pipeline exception flags, invalid in bit 0
//   fp_neg      : sign flip used to turn a - b into a + (-b)
package fp_addsub_arbiter_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp_32b_t;

    localparam logic [2:0] RNE = 3'b000;
    localparam logic [2:0] RTZ = 3'b001;
    localparam logic [2:0] RDN = 3'b010;
    localparam logic [2:0] RUP = 3'b011;
    localparam logic [2:0] RMM = 3'b100;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
        logic invalid;
    } fp_flags_t;

    // Flips the sign unconditionally, NaN/inf/zero included; the pipeline
    // owns all special-value semantics.
    function automatic fp_32b_t fp_neg(input fp_32b_t x);
        fp_32b_t r;
        r      = x;
        r.sign = ~x.sign;
        return r;
    endfunction

endpackage

// File: rtl/fp_addsub_arbiter_arb.sv
// Round-robin arbiter.
//   clk, rst     : clock, async active-high reset
//   req          : request vector
//   en           : 0 forces an empty grant
//   accept       : a grant was taken this cycle; pointer moves to the winner
//   grant_onehot : one-hot winner (combinational)
//   grant_idx    : binary index of the winner
// Search starts at ptr+1 and wraps; ptr resets to N-1 so index 0 wins first.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             accept,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr <= IDX_W'(N - 1);
        else if (accept) ptr <= grant_idx;
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one fp add/sub pipeline among NUM_REQ requesters.
//   clk, rst            : clock, async active-high reset
//   en                  : gates new grants only; in-flight ops always drain
//   req_valid/ready     : per-requester handshake, ready is a one-hot grant
//   req_op/a/b/rm       : per-requester opcode, operands, rounding mode
//   pipe_valid/in1/in2/rm : registered pipeline inputs (SUB folded into ADD)
//   pipe_vout/out/flags : pipeline results, returned in issue order
//   resp_valid/data/flags : one-hot strobe plus result to the owning requester
//   tag_err             : sticky, a result arrived with no outstanding tag
module fp_addsub_arbiter
    import fp_addsub_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LAT     = 4,
    parameter int MAX_INFLIGHT = PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]   req_rm,
    output logic                   pipe_valid,
    output logic [31:0]            pipe_in1,
    output logic [31:0]            pipe_in2,
    output logic [2:0]             pipe_rm,
    input  logic                   pipe_vout,
    input  logic [31:0]            pipe_out,
    input  logic [3:0]             pipe_flags,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    output logic [3:0]             resp_flags,
    output logic                   tag_err
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [ID_W-1:0]  grant_idx;
    logic             can_issue, transfer, pop;
    fp_32b_t          sel_a, sel_b;
    logic             sel_op;
    logic [2:0]       sel_rm;
    fp_flags_t        flags_in;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    // At full, a result popping this cycle frees the slot the new push takes.
    // Gated by rst so req_ready reads 0 the instant reset asserts.
    assign can_issue = en && !rst &&
                       ((count < CNT_W'(MAX_INFLIGHT)) ||
                        (count == CNT_W'(MAX_INFLIGHT) && pipe_vout));
    assign transfer  = |(req_valid & req_ready);
    assign pop       = pipe_vout && (count != '0);
    assign flags_in  = pipe_flags;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (req_valid),
        .en           (can_issue),
        .accept       (transfer),
        .grant_onehot (req_ready),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = OP_ADD;
        sel_rm = RNE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_a  = req_a[32*i +: 32];
                sel_b  = req_b[32*i +: 32];
                sel_op = req_op[i];
                sel_rm = req_rm[3*i +: 3];
            end
        end
    end

    // Pipeline input registers; data holds when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_in1   <= '0;
            pipe_in2   <= '0;
            pipe_rm    <= '0;
        end else begin
            pipe_valid <= transfer;
            if (transfer) begin
                pipe_in1 <= sel_a;
                pipe_in2 <= (sel_op == OP_SUB) ? fp_neg(sel_b) : sel_b;
                pipe_rm  <= sel_rm;
            end
        end
    end

    // Tag FIFO: results come back in issue order, so a plain circular buffer
    // of requester IDs is enough to route them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (transfer) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)      rd_ptr <= ptr_inc(rd_ptr);
            case ({transfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (transfer) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
            tag_err    <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (pop) begin
                resp_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
                resp_data  <= pipe_out;
                resp_flags <= flags_in;
            end
            if (pipe_vout && count == '0) tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
module tb_fp_addsub_arbiter;
    import fp_addsub_arbiter_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int PIPE_LAT = 4;
    localparam int MAX_INF  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_op, resp_valid;
    logic [32*NUM_REQ-1:0] req_a, req_b;
    logic [3*NUM_REQ-1:0]  req_rm;
    logic                  pipe_valid, pipe_vout, tag_err, force_vout;
    logic [31:0]           pipe_in1, pipe_in2, pipe_out, resp_data;
    logic [2:0]            pipe_rm;
    logic [3:0]            pipe_flags, resp_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT), .MAX_INFLIGHT(MAX_INF)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .pipe_valid(pipe_valid), .pipe_in1(pipe_in1), .pipe_in2(pipe_in2), .pipe_rm(pipe_rm),
        .pipe_vout(pipe_vout), .pipe_out(pipe_out), .pipe_flags(pipe_flags),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
        .tag_err(tag_err)
    );

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pipeline stand-in: known IEEE cases by table, a cheap deterministic
    // function otherwise; {flags, data}.
    function automatic logic [35:0] pipe_fn(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            64'h3F800000_40000000: return {4'b0000, 32'h40400000};
            64'h40400000_BF800000: return {4'b0000, 32'h40000000};
            64'h7F800000_FF800000: return {4'b0001, 32'h7FC00000};
            64'h7FA00000_3F800000: return {4'b0001, 32'h7FE00000};
            default:               return {x[3:0] ^ y[3:0], x + y};
        endcase
    endfunction

    logic [PIPE_LAT:0] mv;
    logic [35:0]       md [0:PIPE_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) mv <= '0;
        else begin
            mv    <= {mv[PIPE_LAT-1:0], pipe_valid};
            md[0] <= pipe_fn(pipe_in1, pipe_in2);
            for (int k = 1; k <= PIPE_LAT; k++) md[k] <= md[k-1];
        end
    end
    assign pipe_vout  = mv[PIPE_LAT] | force_vout;
    assign pipe_out   = md[PIPE_LAT][31:0];
    assign pipe_flags = md[PIPE_LAT][35:32];

    // Monitor: grant model, pipeline-input check, scoreboard.
    typedef struct { int id; logic [31:0] d; logic [3:0] f; } sb_t;
    sb_t sb[$];
    int m_ptr, m_out, n_ptr, n_out;
    logic e_pv, n_pv;
    logic [31:0] e_in1, e_in2, n_in1, n_in2;
    logic [2:0] e_rm, n_rm;
    int saw_block = 0, saw_full_grant = 0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [NUM_REQ-1:0] er;
            logic [31:0] b2;
            int gi;
            bit can, pop;
            can = en && (m_out < MAX_INF || (m_out == MAX_INF && pipe_vout));
            er = '0;
            gi = -1;
            if (can)
                for (int k = 1; k <= NUM_REQ; k++)
                    if (gi < 0 && req_valid[(m_ptr + k) % NUM_REQ]) gi = (m_ptr + k) % NUM_REQ;
            if (gi >= 0) er[gi] = 1'b1;
            chk("grant", req_ready, er);
            if (en && req_valid != '0 && m_out == MAX_INF && !pipe_vout) saw_block++;
            if (gi >= 0 && m_out == MAX_INF) saw_full_grant++;
            chk("pipe_valid", pipe_valid, e_pv);
            if (e_pv) begin
                chk("pipe_in1", pipe_in1, e_in1);
                chk("pipe_in2", pipe_in2, e_in2);
                chk("pipe_rm", pipe_rm, e_rm);
            end
            pop = pipe_vout && m_out != 0;
            if (resp_valid != '0) begin
                if (sb.size() == 0) chk("resp_unexpected", resp_valid, 0);
                else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("resp_route", resp_valid, 1 << e.id);
                    chk("resp_data", resp_data, e.d);
                    chk("resp_flags", resp_flags, e.f);
                end
            end
            n_pv  = (gi >= 0);
            n_ptr = (gi >= 0) ? gi : m_ptr;
            n_out = m_out + ((gi >= 0) ? 1 : 0) - (pop ? 1 : 0);
            if (gi >= 0) begin
                sb_t e;
                b2    = req_b[32*gi +: 32];
                if (req_op[gi]) b2[31] = ~b2[31];
                n_in1 = req_a[32*gi +: 32];
                n_in2 = b2;
                n_rm  = req_rm[3*gi +: 3];
                e.id  = gi;
                {e.f, e.d} = pipe_fn(n_in1, n_in2);
                sb.push_back(e);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr <= NUM_REQ - 1;
            m_out <= 0;
            e_pv  <= 1'b0;
            sb.delete();
        end else begin
            m_ptr <= n_ptr;
            m_out <= n_out;
            e_pv  <= n_pv;
            if (n_pv) begin
                e_in1 <= n_in1;
                e_in2 <= n_in2;
                e_rm  <= n_rm;
            end
        end
    end

    typedef struct {
        int id; logic op; logic [31:0] a, b; logic [2:0] rm;
        logic [31:0] ed; logic [3:0] ef;
    } vec_t;
    vec_t vt[6];

    task automatic run_vec(input vec_t v);
        int lat;
        bit ok;
        req_a[32*v.id +: 32] = v.a;
        req_b[32*v.id +: 32] = v.b;
        req_op[v.id]         = v.op;
        req_rm[3*v.id +: 3]  = v.rm;
        req_valid            = '0;
        req_valid[v.id]      = 1'b1;
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready[v.id];
            if (!ok) @(posedge clk);
        end
        chk("vec_grant", ok, 1);
        @(posedge clk); #1;
        req_valid = '0;
        ok = 0;
        lat = 0;
        for (int n = 1; n <= 20 && !ok; n++) begin
            @(posedge clk); #1;
            lat = n;
            ok  = resp_valid[v.id];
        end
        chk("vec_resp_seen", ok, 1);
        chk("vec_latency", lat, PIPE_LAT + 2);
        chk("vec_data", resp_data, v.ed);
        chk("vec_flags", resp_flags, v.ef);
    endtask

    task automatic burst(input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_a[32*i +: 32] = $urandom;
                req_b[32*i +: 32] = $urandom;
                req_op[i]         = 1'($urandom_range(0, 1));
                req_rm[3*i +: 3]  = 3'($urandom_range(0, 4));
            end
            req_valid = '1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = '1; req_op = '0;
        req_a = '0; req_b = '0; req_rm = '0; force_vout = 1'b0;
        vt[0] = '{0, OP_ADD, 32'h3F800000, 32'h40000000, RNE, 32'h40400000, 4'b0000};
        vt[1] = '{2, OP_SUB, 32'h40400000, 32'h3F800000, RTZ, 32'h40000000, 4'b0000};
        vt[2] = '{1, OP_SUB, 32'h7F800000, 32'h7F800000, RDN, 32'h7FC00000, 4'b0001};
        vt[3] = '{3, OP_ADD, 32'h7FA00000, 32'h3F800000, RUP, 32'h7FE00000, 4'b0001};
        vt[4] = '{1, OP_ADD, 32'h00000005, 32'h00000003, RMM, 32'h00000008, 4'b0110};
        vt[5] = '{3, OP_SUB, 32'h00000010, 32'h00000001, RNE, 32'h80000011, 4'b0001};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pipe_valid", pipe_valid, 0);
        chk("rst_pipe_in1", pipe_in1, 0);
        chk("rst_pipe_in2", pipe_in2, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_tag_err", tag_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        foreach (vt[i]) run_vec(vt[i]);

        // Continuous traffic from all requesters: rotation and full-FIFO stall.
        burst(40);
        en = 1'b0;
        burst(8);
        req_valid = '0;
        en = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("drain_sb_empty", sb.size(), 0);
        chk("full_block_seen", saw_block > 0, 1);
        chk("full_vout_grant_seen", saw_full_grant > 0, 1);
        chk("tag_err_clean", tag_err, 0);

        // Stray result with nothing outstanding.
        force_vout = 1'b1;
        @(posedge clk); #1;
        force_vout = 1'b0;
        @(posedge clk); #1;
        chk("tag_err_set", tag_err, 1);
        chk("tag_err_no_resp", resp_valid, 0);

        // Reset while ops are in flight.
        burst(5);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_pipe_valid", pipe_valid, 0);
        chk("midrst_pipe_in2", pipe_in2, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_tag_err", tag_err, 0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_tag_err", tag_err, 0);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
